// File: rtl/regfile_wb.sv
// RV32I integer register file fed by the MEM/WB writeback triple, with a commit counter.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_wb #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] SP_RESET  = '0,
  parameter int              CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 register_write_enable_in,
  input  logic [4:0]           instruction_rd_in,
  input  logic [XLEN-1:0]      wb_data_in,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [CNT_WIDTH-1:0] wb_commit_count,
  output logic                 wb_commit
);

  // x0 has no storage; it is synthesised as a constant zero on the read side.
  logic [XLEN-1:0] regs [1:31];
  logic            commit_now;

  assign commit_now = register_write_enable_in && (instruction_rd_in != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == 2) ? SP_RESET : '0;
      end
      wb_commit       <= 1'b0;
      wb_commit_count <= '0;
    end else begin
      wb_commit <= commit_now;
      if (commit_now) begin
        regs[instruction_rd_in] <= wb_data_in;
        wb_commit_count         <= wb_commit_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  function automatic logic [XLEN-1:0] stored_value(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end
    return regs[addr];
  endfunction

`ifdef REGFILE_WB_BYPASS_EN
  // Forwarding is suppressed during reset so reads show the cleared contents.
  logic bypass1;
  logic bypass2;

  assign bypass1 = !rst && commit_now && (rs1_addr == instruction_rd_in);
  assign bypass2 = !rst && commit_now && (rs2_addr == instruction_rd_in);

  always_comb begin
    rs1_data = stored_value(rs1_addr);
    rs2_data = stored_value(rs2_addr);
    if (bypass1) begin
      rs1_data = wb_data_in;
    end
    if (bypass2) begin
      rs2_data = wb_data_in;
    end
  end
`else
  always_comb begin
    rs1_data = stored_value(rs1_addr);
    rs2_data = stored_value(rs2_addr);
  end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Randomised bench for regfile_wb compared every cycle against an array-based register model.
// Directed sections pin the model with literal values for reset, x0, same-cycle reads, wrap and async reset.
module tb_regfile_wb;

  localparam int              XLEN      = 32;
  localparam logic [31:0]     SP_INIT   = 32'h0000_1000;
  localparam int              CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 we;
  logic [4:0]           rd;
  logic [XLEN-1:0]      wdata;
  logic [4:0]           ra1;
  logic [4:0]           ra2;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;
  logic [CNT_WIDTH-1:0] wb_commit_count;
  logic                 wb_commit;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  logic [XLEN-1:0]      model_regs [32];
  logic [CNT_WIDTH-1:0] model_count;
  logic                 model_commit;

  regfile_wb #(
    .XLEN      (XLEN),
    .SP_RESET  (SP_INIT),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .register_write_enable_in (we),
    .instruction_rd_in        (rd),
    .wb_data_in               (wdata),
    .rs1_addr                 (ra1),
    .rs2_addr                 (ra2),
    .rs1_data                 (rs1_data),
    .rs2_data                 (rs2_data),
    .wb_commit_count          (wb_commit_count),
    .wb_commit                (wb_commit)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
    end
    model_regs[2] = SP_INIT;
    model_count   = '0;
    model_commit  = 1'b0;
  endtask

  // The architectural effect of one edge: a write to any nonzero rd is one commit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      model_commit = we && (rd != 5'd0);
      if (model_commit) begin
        model_regs[rd] = wdata;
        model_count    = model_count + 1'b1;
      end
    end
  end

  function automatic logic [XLEN-1:0] expected_read(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end
`ifdef REGFILE_WB_BYPASS_EN
    if (!rst && we && (rd != 5'd0) && (addr == rd)) begin
      return wdata;
    end
`endif
    return model_regs[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("rs1_data", rs1_data, expected_read(ra1));
      checkOutput("rs2_data", rs2_data, expected_read(ra2));
      checkOutput("wb_commit", {31'd0, wb_commit}, {31'd0, model_commit});
      checkOutput("wb_commit_count", {28'd0, wb_commit_count}, {28'd0, model_count});
    end
  end

  // Inputs change just after a rising edge; returns mid-cycle, after the compare process.
  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] d,
                               input logic [31:0] data, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst   = r;
    we    = w;
    rd    = d;
    wdata = data;
    ra1   = a1;
    ra2   = a2;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rd = '0; wdata = '0; ra1 = 5'd2; ra2 = 5'd5;
    model_reset();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
    compare_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
    checkOutput("reset_sp", rs1_data, 32'h0000_1000);
    checkOutput("reset_x5", rs2_data, 32'h0);
    checkOutput("reset_count", {28'd0, wb_commit_count}, 32'd0);

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("basic_read", rs1_data, 32'hDEAD_BEEF);
    checkOutput("basic_pulse", {31'd0, wb_commit}, 32'd1);
    checkOutput("basic_count", {28'd0, wb_commit_count}, 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("x0_read", rs1_data, 32'h0);
    checkOutput("x0_pulse", {31'd0, wb_commit}, 32'd0);
    checkOutput("x0_count", {28'd0, wb_commit_count}, 32'd1);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
`ifdef REGFILE_WB_BYPASS_EN
    checkOutput("same_cycle_rs1", rs1_data, 32'h2);
`else
    checkOutput("same_cycle_rs1", rs1_data, 32'h1);
`endif
    checkOutput("same_cycle_ports", rs2_data, rs1_data);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("after_write_rs1", rs1_data, 32'h2);
    checkOutput("after_write_rs2", rs2_data, 32'h2);

    applyStimulus(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd10, 32'h0000_1234, 5'd9, 5'd10);
    checkOutput("x9_before_reset", rs1_data, 32'hA5A5_A5A5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_x9_cleared", rs1_data, 32'h0);
    checkOutput("async_count_cleared", {28'd0, wb_commit_count}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd10, 32'h0000_5678, 5'd10, 5'd9);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
    checkOutput("write_lost_in_reset", rs1_data, 32'h0);
    checkOutput("count_after_reset", {28'd0, wb_commit_count}, 32'd0);

    for (int i = 1; i <= 18; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      applyStimulus(1'b0, i <= 17, r, $urandom, r, 5'd2);
      if (i == 16) checkOutput("wrap_15", {28'd0, wb_commit_count}, 32'd15);
      if (i == 17) checkOutput("wrap_0", {28'd0, wb_commit_count}, 32'd0);
      if (i == 18) checkOutput("wrap_1", {28'd0, wb_commit_count}, 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      logic [4:0] r;
      logic [4:0] a1;
      logic [4:0] a2;
      r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom);
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, r, $urandom, a1, a2);
    end

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- RV32I integer register file: the consumer end of the MEM/WB pipeline register.
- Accepts the writeback triple (rd, data, write-enable) each cycle and commits it to the architectural registers x0..x31.
- Provides two combinational read ports to the decode stage.
- Keeps a count of committed writebacks for performance and debug.

Parameters:
- XLEN, 32, data width of every register and of the read/write data ports.
- SP_RESET, 32'h0000_0000, reset value of x2 (sp); every other register resets to 0.
- CNT_WIDTH, 32, width of the writeback commit counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- register_write_enable_in  input  1  writeback request from MEM/WB.
- instruction_rd_in  input  5  destination register index.
- wb_data_in  input  XLEN  writeback data.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.
- wb_commit_count  output  CNT_WIDTH  number of committed writes since reset.
- wb_commit  output  1  registered pulse: a write committed on the previous edge.

Behaviour:
- Reset (asynchronous, active-high):
  - While rst=1: x1..x31 = 0 except x2 = SP_RESET.
  - wb_commit_count = 0, wb_commit = 0.
  - Read ports reflect the reset contents immediately.
- Commit:
  - A write commits on the rising edge when register_write_enable_in=1 and instruction_rd_in != 0.
  - On commit: reg[rd] <= wb_data_in, wb_commit <= 1, wb_commit_count <= wb_commit_count + 1.
  - Otherwise wb_commit <= 0 and the counter holds.
- x0:
  - Hardwired zero; reads of index 0 always return 0.
  - A write with rd=0 is discarded entirely: no storage change, no wb_commit pulse, no count.
- Counter: wraps modulo 2^CNT_WIDTH (all-ones + 1 -> 0) with no sticky flag.
- Reads:
  - Combinational from current storage (zero latency).
  - rs1 and rs2 are independent; both may address the same register.
- Read/write same cycle, same register, without bypass: the read returns the old value; the new value is visible the cycle after the edge.
- No stall input. Stalling is handled upstream by the MEM/WB enable, which holds register_write_enable_in stable; a held write simply rewrites the same value.
  - Each cycle the enable is held counts as a separate commit.
- Reset asserted mid-cycle: clears storage and counter immediately; a write on the same edge is lost.
- Reset deasserted: the first edge with rst=0 may commit.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: write-through bypass. If register_write_enable_in=1, instruction_rd_in != 0 and rsN_addr == instruction_rd_in, then rsN_data = wb_data_in combinationally in the same cycle.
  - Removes the WB->ID hazard.
  - rd=0 is never bypassed.
  - Bypass is inactive while rst=1.
- Undefined: reads return stored contents only; the old value is seen in the write cycle. The hazard unit must stall one cycle.

Test Plan:
- Reset: assert rst with SP_RESET=32'h0000_1000 -> rs1_addr=2 reads 32'h0000_1000; rs2_addr=5 reads 0; wb_commit_count=0.
- Basic write: we=1, rd=5, data=32'hDEAD_BEEF for one cycle -> next cycle rs1_addr=5 reads 32'hDEAD_BEEF; wb_commit pulses 1 for one cycle; count=1.
- x0 write: we=1, rd=0, data=32'hFFFF_FFFF -> rs1_addr=0 reads 0; wb_commit stays 0; count unchanged.
- Same-cycle read/write, rd=7: reg 7 holds 32'h1, new data 32'h2:
  - Bypass undefined -> reads 32'h1 in the write cycle, 32'h2 after.
  - Bypass defined -> reads 32'h2 in the same cycle.
  - Both ports at 7 -> identical values.
- Counter wrap: CNT_WIDTH=4, 17 commits -> count reads 15 after the 15th commit, 0 after the 16th, 1 after the 17th.
- Async reset mid-write: rst asserted between edges after x9=32'hA5A5_A5A5 -> rs1_data for index 9 drops to 0 before the next edge; a write presented on the first edge with rst still high is not stored.
